aes_ctr_stream_engine: RTL
==========================

Name: aes_ctr_stream_engine

Overview:
Parametrised CTR-mode streaming engine, the successor to the fixed aes256_ctr_mode datapath. Generates counter blocks and issues them to an external block-cipher core over a valid/ready request port. Prefetches the returned keystream into a KS_DEPTH buffer and XORs it with AXI-Stream payload, with byte-granular tkeep, configurable counter width, and a flush/restart on a new IV. Sits between the DMA-side AXI-Stream and the AES-256 core; the key is wired to the core directly and never passes through this block.

Parameters:
- CTR_W, 32: width of the incrementing counter field (IV bits [CTR_W-1:0]); legal range 8..128.
- KS_DEPTH, 4: keystream buffer depth in 128-bit blocks; power of two, range 2..16.
- MAX_OUTST, KS_DEPTH: maximum cipher requests in flight; must not exceed KS_DEPTH.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- cfg_start, in, 1: one-cycle pulse; loads cfg_iv and (re)starts a message.
- cfg_iv, in, 128: initial counter block, sampled on cfg_start.
- c_req_valid, out, 1: counter block request to the cipher core.
- c_req_ready, in, 1: cipher core accepts the request.
- c_req_data, out, 128: counter block.
- c_rsp_valid, in, 1: keystream block returned; no backpressure.
- c_rsp_data, in, 128: keystream block.
- s_axis_tready, out, 1.
- s_axis_tvalid, in, 1.
- s_axis_tlast, in, 1.
- s_axis_tkeep, in, 16.
- s_axis_tdata, in, 128.
- m_axis_tready, in, 1.
- m_axis_tvalid, out, 1.
- m_axis_tlast, out, 1.
- m_axis_tkeep, out, 16.
- m_axis_tdata, out, 128.
- busy, out, 1: state is not IDLE.
- ks_level, out, $clog2(KS_DEPTH)+1: keystream blocks currently buffered.
- blk_count, out, 32: beats output since the last cfg_start; wraps.
- err_wrap, out, 1: sticky counter-wrap flag; cleared by cfg_start.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, buffer empty, outstanding count 0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE + cfg_start -> RUN.
  - RUN + cfg_start -> FLUSH.
  - RUN, accepted input beat with tlast=1 -> FLUSH.
  - FLUSH, outstanding==0 -> RUN if a start is pending, else IDLE.
- On cfg_start in any state: ctr <= cfg_iv; buffer cleared; blk_count and err_wrap cleared; pending-start flag set if not entering RUN directly.
- Request issue: c_req_valid=1 only in RUN and when ks_level + outstanding < KS_DEPTH and outstanding < MAX_OUTST. c_req_data is the current ctr.
  - Request handshake: ctr[CTR_W-1:0] increments modulo 2^CTR_W; ctr[127:CTR_W] never changes.
  - Wrap from all-ones to 0 sets err_wrap.
  - Counter byte order is big-endian: bit 127 is byte 0. IV ..FCFDFEFF becomes ..FCFDFF00.
- Response handling: push to buffer in RUN. Discard in FLUSH, but still decrement outstanding.
  - A response arriving with the buffer full is a protocol error; it cannot occur by construction.
- Output register: one stage.
  - s_axis_tready = RUN & ks_level>0 & (!m_axis_tvalid | m_axis_tready).
  - On an input beat: m_tdata = s_tdata ^ ks_head, with byte i forced to 0 where tkeep[i]=0; tkeep and tlast pass through; pop buffer; blk_count++.
  - Latency: input beat to m_axis_tvalid is 1 cycle.
- m_axis_tvalid holds until m_axis_tready. An output beat still pending is delivered during FLUSH and IDLE, never dropped.
- Simultaneous events:
  - cfg_start wins over an input beat in the same cycle: the beat is not accepted, because tready is forced to 0 when cfg_start=1.
  - Same-cycle response push and pop are both applied; ks_level is unchanged.
- Reset mid-operation aborts everything. The cipher core shares rst_n, so no stale responses follow.

Optional Feature:
- Macro CTR_WRAP_GUARD_EN.
- Defined: when an increment would wrap ctr[CTR_W-1:0] to 0, no further requests are issued and err_wrap is set. Already-buffered keystream drains, then s_axis_tready stays 0 until cfg_start.
- Undefined: the counter wraps silently and only err_wrap is set.

Decomposition:
- Package aes_ctr_pkg holds:
  - BLOCK_W=128 and KEEP_W=16;
  - the state enum ctr_state_e (IDLE, RUN, FLUSH);
  - function ctr_inc(blk, CTR_W).
- One natural sub-module: ctr_ks_fifo, a synchronous FIFO of KS_DEPTH×128 with clear, push, pop and level.

Test Plan:
1. NIST SP800-38A F.5.5, with the AES-256 core attached.
   - Stimulus: key 603DEB10…0914DFF4, IV F0F1…FEFF, plaintext 6BC1BEE2…, AE2D8A57…, 30C81C46…, F69F2445… (tlast on the 4th beat).
   - Required output: 601EC313…BBF3D228, F443E3CA…CACAF5C5, 2B0930DA…2D84988D, DFC9C58D…457941A6. busy=0 after drain.
2. Identity cipher stub (rsp=req, 3-cycle latency), IV=0, four zero beats -> outputs 0…0, 0…1, 0…2, 0…3 (low bits). ks_level never exceeds 4.
3. Identity stub, tkeep=16'h00FF, data all-FF, IV=0 -> tdata=00000000_00000000_FFFFFFFF_FFFFFFFF, tkeep=16'h00FF.
4. Identity stub, m_axis_tready toggled 1-0-1 every cycle for 200 beats -> no beat lost or duplicated; blk_count=200; counter sequence contiguous.
5. IV low 32 bits = FFFFFFFE, CTR_W=32, three beats.
   - Macro off: counters …FFFFFFFE, …FFFFFFFF, …00000000; err_wrap=1.
   - Macro on: two beats output, then tready stays 0; err_wrap=1.
6. cfg_start mid-message with 2 requests outstanding -> FLUSH; stale responses discarded. The first output after restart uses the new IV counter; ks_level returns to 0 during FLUSH.

Source files
------------

// File: rtl/aes_ctr_pkg.sv
// Shared types and helpers for the CTR-mode streaming engine.
package aes_ctr_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEEP_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ctr_state_e;

  // Mask covering the incrementing counter field, bits [ctr_w-1:0].
  function automatic logic [BLOCK_W-1:0] ctr_field_mask(input int ctr_w);
    logic [BLOCK_W-1:0] m;
    m = '0;
    for (int i = 0; i < BLOCK_W; i++) begin
      m[i] = (i < ctr_w);
    end
    return m;
  endfunction

  // Increment the low ctr_w bits modulo 2^ctr_w; upper bits are untouched.
  function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] blk,
                                                 input int ctr_w);
    logic [BLOCK_W-1:0] m;
    m = ctr_field_mask(ctr_w);
    return (blk & ~m) | ((blk + 128'd1) & m);
  endfunction

endpackage

// File: rtl/aes_ctr_stream_engine_fifo.sv
// Keystream buffer: DEPTH x WIDTH synchronous FIFO with clear, push, pop, level.
// DEPTH must be a power of two so the pointers wrap naturally.
module ctr_ks_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Pointers and occupancy; clear wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/aes_ctr_stream_engine.sv
// CTR-mode streaming engine: issues counter blocks to an external cipher core,
// prefetches keystream and XORs it onto an AXI-Stream payload.
// Optional build macro CTR_WRAP_GUARD_EN: stop issuing requests once the
// counter field would wrap; otherwise wrap silently and only flag err_wrap.
//
// state | meaning
// IDLE  | no message active, no requests issued
// RUN   | issuing counter requests and accepting payload beats
// FLUSH | discarding in-flight responses until none are outstanding
module aes_ctr_stream_engine
  import aes_ctr_pkg::*;
#(
  parameter int CTR_W     = 32,
  parameter int KS_DEPTH  = 4,
  parameter int MAX_OUTST = KS_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic [127:0]              cfg_iv,
  output logic                      c_req_valid,
  input  logic                      c_req_ready,
  output logic [127:0]              c_req_data,
  input  logic                      c_rsp_valid,
  input  logic [127:0]              c_rsp_data,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  input  logic [15:0]               s_axis_tkeep,
  input  logic [127:0]              s_axis_tdata,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [15:0]               m_axis_tkeep,
  output logic [127:0]              m_axis_tdata,
  output logic                      busy,
  output logic [$clog2(KS_DEPTH):0] ks_level,
  output logic [31:0]               blk_count,
  output logic                      err_wrap
);

  localparam int LW = $clog2(KS_DEPTH) + 1;
  localparam logic [BLOCK_W-1:0] CTR_MASK = ctr_field_mask(CTR_W);
  localparam logic [LW:0]        DEPTH_L  = (LW+1)'(KS_DEPTH);
  localparam logic [LW-1:0]      OUTST_L  = LW'(MAX_OUTST);

  ctr_state_e         state;
  ctr_state_e         state_nxt;
  logic [BLOCK_W-1:0] ctr;
  logic [BLOCK_W-1:0] ctr_next;
  logic [LW-1:0]      outst;
  logic               start_pending;
  logic               wrap_hold;
  logic               wrap_now;
  logic               room;
  logic               req_fire;
  logic               in_fire;
  logic               rsp_push;
  logic               out_free;
  logic [BLOCK_W-1:0] ks_head;
  logic [BLOCK_W-1:0] xor_data;

  assign ctr_next = ctr_inc(ctr, CTR_W);
  assign wrap_now = (ctr_next & CTR_MASK) == '0;
  assign room     = ({1'b0, ks_level} + {1'b0, outst}) < DEPTH_L;

  // cfg_start suppresses both request issue and beat acceptance that cycle.
  assign c_req_valid   = (state == RUN) && room && (outst < OUTST_L) &&
                         !cfg_start && !wrap_hold;
  assign c_req_data    = ctr;
  assign req_fire      = c_req_valid && c_req_ready;
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == RUN) && (ks_level != '0) && out_free && !cfg_start;
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign rsp_push      = c_rsp_valid && (state == RUN);
  assign busy          = (state != IDLE);

  ctr_ks_fifo #(
    .DEPTH (KS_DEPTH),
    .WIDTH (BLOCK_W)
  ) u_ks_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cfg_start),
    .push      (rsp_push),
    .push_data (c_rsp_data),
    .pop       (in_fire),
    .head      (ks_head),
    .level     (ks_level)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; FLUSH leaves only once the core has nothing in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = RUN;
      RUN:     if (cfg_start || (in_fire && s_axis_tlast)) state_nxt = FLUSH;
      FLUSH:   if (outst == '0) state_nxt = (start_pending || cfg_start) ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, outstanding tracking, restart bookkeeping and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr           <= '0;
      outst         <= '0;
      start_pending <= 1'b0;
      err_wrap      <= 1'b0;
      blk_count     <= '0;
    end else begin
      case ({req_fire, c_rsp_valid})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
      if (cfg_start) begin
        ctr           <= cfg_iv;
        err_wrap      <= 1'b0;
        blk_count     <= '0;
        start_pending <= (state_nxt != RUN);
      end else begin
        if (req_fire) begin
          ctr <= ctr_next;
          if (wrap_now) err_wrap <= 1'b1;
        end
        if (in_fire) blk_count <= blk_count + 32'd1;
        if (state == FLUSH && state_nxt == RUN) start_pending <= 1'b0;
      end
    end
  end

`ifdef CTR_WRAP_GUARD_EN
  // Latch a wrap so no request reuses a counter value until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wrap_hold <= 1'b0;
    else if (cfg_start)            wrap_hold <= 1'b0;
    else if (req_fire && wrap_now) wrap_hold <= 1'b1;
  end
`else
  assign wrap_hold = 1'b0;
`endif

  // Payload XOR with byte masking from tkeep (bit i covers tdata[8i+7:8i]).
  always_comb begin
    xor_data = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (s_axis_tkeep[i]) xor_data[8*i +: 8] = s_axis_tdata[8*i +: 8] ^ ks_head[8*i +: 8];
    end
  end

  // Single output register stage; a held beat survives FLUSH/IDLE and restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tdata  <= '0;
    end else if (in_fire) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tdata  <= xor_data;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
